// File: rtl/cmd_ram_param.sv
// Command-driven single-port RAM with a valid/ready read-out channel.
// Optional feature macro: CMD_RAM_AUTO_INC_EN (address auto-increment after each write/read).
module cmd_ram_param #(
    parameter int ADDR_SIZE  = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH+1:0] din,
    input  logic                  rx_valid,
    input  logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  tx_valid,
    output logic                  err
);

    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [ADDR_SIZE:0] DEPTH_W = (ADDR_SIZE+1)'(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    state_t                state_q;
    logic [ADDR_SIZE-1:0]  waddr_q, waddr_d;
    logic [ADDR_SIZE-1:0]  raddr_q, raddr_d;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  tx_valid_q;
    logic                  err_q;

    logic [1:0]            cmd;
    logic [DATA_WIDTH-1:0] payload;
    logic [ADDR_SIZE-1:0]  paddr;
    logic                  addr_ok;
    logic                  set_w, wr, set_r, rd;
    logic                  rd_acc, rd_drop, reject;

    assign cmd     = din[DATA_WIDTH+1:DATA_WIDTH];
    assign payload = din[DATA_WIDTH-1:0];
    assign paddr   = payload[ADDR_SIZE-1:0];
    assign addr_ok = {1'b0, paddr} < DEPTH_W;

    assign set_w = rx_valid && (cmd == 2'b00);
    assign wr    = rx_valid && (cmd == 2'b01);
    assign set_r = rx_valid && (cmd == 2'b10);
    assign rd    = rx_valid && (cmd == 2'b11);

    // A read is taken unless a word is still waiting for a consumer that is not ready.
    assign rd_acc  = rd && ((state_q == IDLE) || tx_ready);
    assign rd_drop = rd && (state_q == HOLD) && !tx_ready;
    assign reject  = ((set_w || set_r) && !addr_ok) || rd_drop;

`ifdef CMD_RAM_AUTO_INC_EN
    localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(MEM_DEPTH - 1);

    function automatic logic [ADDR_SIZE-1:0] inc(input logic [ADDR_SIZE-1:0] a);
        return (a == LAST) ? '0 : a + 1'b1;
    endfunction
`endif

    always_comb begin
        waddr_d = waddr_q;
        raddr_d = raddr_q;
        if (set_w && addr_ok) waddr_d = paddr;
        if (set_r && addr_ok) raddr_d = paddr;
`ifdef CMD_RAM_AUTO_INC_EN
        if (wr)     waddr_d = inc(waddr_q);
        if (rd_acc) raddr_d = inc(raddr_q);
`endif
    end

    // Storage carries no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (wr && !rst) mem[waddr_q] <= payload;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            waddr_q    <= '0;
            raddr_q    <= '0;
            dout_q     <= '0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            waddr_q <= waddr_d;
            raddr_q <= raddr_d;
            err_q   <= reject;
            case (state_q)
                IDLE: begin
                    if (rd_acc) begin
                        dout_q     <= mem[raddr_q];
                        tx_valid_q <= 1'b1;
                        state_q    <= HOLD;
                    end
                end
                HOLD: begin
                    if (rd_acc) begin
                        dout_q <= mem[raddr_q];
                    end else if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    tx_valid_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign dout     = dout_q;
    assign tx_valid = tx_valid_q;
    assign err      = err_q;

endmodule

// File: tb/tb_cmd_ram_param.sv
// Bench for cmd_ram_param: directed scenarios plus randomized traffic vs. a transaction-level model.
module tb_cmd_ram_param;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] din;
    logic       rx_valid, tx_ready;
    logic [7:0] dout, dout2;
    logic       tx_valid, tx_valid2, err, err2;

    int checks = 0;
    int errors = 0;

    cmd_ram_param dut (
        .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid), .tx_ready(tx_ready),
        .dout(dout), .tx_valid(tx_valid), .err(err)
    );

    cmd_ram_param #(.ADDR_SIZE(8), .DATA_WIDTH(8), .MEM_DEPTH(200)) dut200 (
        .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid), .tx_ready(tx_ready),
        .dout(dout2), .tx_valid(tx_valid2), .err(err2)
    );

    always #5 clk = ~clk;

    // Transaction-level model of the default (256-word) instance.
    logic [7:0] m_mem [256];
    int         m_wa, m_ra;
    bit         m_hold;
    logic [7:0] m_dout;
    bit         m_err;
`ifdef CMD_RAM_AUTO_INC_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    task automatic cyc(input logic [1:0] c, input logic [7:0] p, input logic v, input logic r);
        bit took;
        din = {c, p}; rx_valid = v; tx_ready = r;
        @(posedge clk);
        #1;
        took  = 0;
        m_err = 0;
        if (rst) begin
            m_wa = 0; m_ra = 0; m_hold = 0; m_dout = 0;
        end else begin
            if (v) begin
                case (c)
                    2'd0: m_wa = int'(p);
                    2'd1: begin m_mem[m_wa] = p; if (AUTO) m_wa = (m_wa + 1) % 256; end
                    2'd2: m_ra = int'(p);
                    default: begin
                        if (!m_hold || r) begin
                            m_dout = m_mem[m_ra]; took = 1;
                            if (AUTO) m_ra = (m_ra + 1) % 256;
                        end else m_err = 1;
                    end
                endcase
            end
            if (took) m_hold = 1;
            else if (m_hold && r) m_hold = 0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc(2'd3, 8'h00, 1'b1, 1'b0);
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", dout); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (tx_valid2 !== 1'b0) begin errors++; $display("FAIL reset_tx_valid200 got %b want 0", tx_valid2); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        cyc(2'd0, 8'h10, 1'b1, 1'b1);
        cyc(2'd1, 8'hA5, 1'b1, 1'b1);
        cyc(2'd2, 8'h10, 1'b1, 1'b1);
        cyc(2'd3, 8'h00, 1'b1, 1'b1);
        checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL basic_dout got %h want a5", dout); end
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL basic_tx_valid got %b want 1", tx_valid); end
        cyc(2'd0, 8'h00, 1'b0, 1'b1);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL basic_tx_drop got %b want 0", tx_valid); end
        checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL basic_dout_kept got %h want a5", dout); end
    endtask

    task automatic test_hold;
        cyc(2'd0, 8'h20, 1'b1, 1'b0);
        cyc(2'd1, 8'h3C, 1'b1, 1'b0);
        cyc(2'd2, 8'h20, 1'b1, 1'b0);
        cyc(2'd3, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 1)      cyc(2'd2, 8'h10, 1'b1, 1'b0);
            else if (i == 2) cyc(2'd3, 8'h00, 1'b1, 1'b0);
            else             cyc(2'd0, 8'h00, 1'b0, 1'b0);
            checks++; if (dout !== 8'h3C) begin errors++; $display("FAIL hold_dout[%0d] got %h want 3c", i, dout); end
            checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL hold_tx_valid[%0d] got %b want 1", i, tx_valid); end
            checks++; if (err !== (i == 2)) begin errors++; $display("FAIL hold_err[%0d] got %b want %b", i, err, i == 2); end
        end
        cyc(2'd0, 8'h00, 1'b0, 1'b1);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL hold_release got %b want 0", tx_valid); end
        cyc(2'd3, 8'h00, 1'b1, 1'b1);
        checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL hold_raddr_kept got %h want a5", dout); end
        cyc(2'd0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_depth;
        rst = 1'b1; cyc(2'd0, 8'h00, 1'b0, 1'b0); rst = 1'b0;
        cyc(2'd0, 8'hC8, 1'b1, 1'b1);
        checks++; if (err2 !== 1'b1) begin errors++; $display("FAIL depth_reject_err got %b want 1", err2); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL depth_full_noerr got %b want 0", err); end
        cyc(2'd1, 8'h5A, 1'b1, 1'b1);
        checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL depth_err_pulse got %b want 0", err2); end
        cyc(2'd2, 8'hC7, 1'b1, 1'b1);
        checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL depth_accept_c7 got %b want 0", err2); end
        cyc(2'd2, 8'h00, 1'b1, 1'b1);
        cyc(2'd3, 8'h00, 1'b1, 1'b1);
        checks++; if (dout2 !== 8'h5A) begin errors++; $display("FAIL depth_waddr_kept got %h want 5a", dout2); end
        cyc(2'd0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_autoinc;
        logic [7:0] e0, e1;
        e0 = AUTO ? 8'h11 : 8'h22;
        e1 = 8'h22;
        cyc(2'd0, 8'hFF, 1'b1, 1'b1);
        cyc(2'd1, 8'h11, 1'b1, 1'b1);
        cyc(2'd1, 8'h22, 1'b1, 1'b1);
        cyc(2'd2, 8'hFF, 1'b1, 1'b1);
        cyc(2'd3, 8'h00, 1'b1, 1'b1);
        checks++; if (dout !== e0) begin errors++; $display("FAIL autoinc_rd0 got %h want %h", dout, e0); end
        cyc(2'd3, 8'h00, 1'b1, 1'b1);
        checks++; if (dout !== e1) begin errors++; $display("FAIL autoinc_rd1 got %h want %h", dout, e1); end
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL autoinc_tx_valid got %b want 1", tx_valid); end
        cyc(2'd0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_reset_hold;
        cyc(2'd2, 8'hFF, 1'b1, 1'b0);
        cyc(2'd3, 8'h00, 1'b1, 1'b0);
        rst = 1'b1;
        cyc(2'd3, 8'h00, 1'b1, 1'b1);
        rst = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rsthold_tx_valid got %b want 0", tx_valid); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rsthold_dout got %h want 00", dout); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rsthold_err got %b want 0", err); end
        cyc(2'd2, 8'h10, 1'b1, 1'b1);
        cyc(2'd3, 8'h00, 1'b1, 1'b1);
        checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL rsthold_mem_kept got %h want a5", dout); end
        cyc(2'd0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_random;
        int bad = 0;
        cyc(2'd0, 8'h00, 1'b1, 1'b1);
        for (int a = 0; a < 256; a++) begin
            cyc(2'd0, 8'(a), 1'b1, 1'b1);
            cyc(2'd1, 8'($urandom), 1'b1, 1'b1);
        end
        for (int i = 0; i < 3000; i++) begin
            cyc(2'($urandom), 8'($urandom), ($urandom_range(3) != 0), 1'($urandom));
            checks++;
            if (dout !== m_dout || tx_valid !== m_hold || err !== m_err) begin
                errors++;
                if (bad++ < 10)
                    $display("FAIL random[%0d] got dout=%h tx_valid=%b err=%b want dout=%h tx_valid=%b err=%b",
                             i, dout, tx_valid, err, m_dout, m_hold, m_err);
            end
        end
    endtask

    initial begin
        rst = 1'b0; din = '0; rx_valid = 1'b0; tx_ready = 1'b0;
        m_wa = 0; m_ra = 0; m_hold = 0; m_dout = 0; m_err = 0;
        test_reset;
        test_basic;
        test_hold;
        test_depth;
        test_autoinc;
        test_reset_hold;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
